// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate data cache controller.
// One word per line; a single outstanding backing-memory request at a time.
module data_cache_ctrl #(
    parameter int N_Bits = 32,
    parameter int LINES  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Storetype,
    input  logic [N_Bits-1:0] A,
    input  logic [N_Bits-1:0] WD,
    output logic [N_Bits-1:0] RD,
    output logic              Stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_storetype,
    output logic [N_Bits-1:0] mem_A,
    output logic [N_Bits-1:0] mem_WD,
    input  logic [N_Bits-1:0] mem_RD,
    input  logic              mem_ready,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_BITS   = N_Bits - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_MEM} state_t;

    state_t state, state_next;

    logic [N_Bits-1:0]   data_arr [LINES];
    logic [TAG_BITS-1:0] tag_arr  [LINES];
    logic [LINES-1:0]    valid;

    logic [N_Bits-1:0]   req_addr;
    logic [N_Bits-1:0]   req_data;
    logic [1:0]          req_type;
    logic                req_we;
    logic                fill_done;

    logic [INDEX_BITS-1:0] cpu_idx, req_idx;
    logic [TAG_BITS-1:0]   cpu_tag, req_tag;
    logic                  cpu_hit, req_hit;
    logic                  is_load, is_store;
    logic                  hit_inc, miss_inc;

    assign cpu_idx  = A[INDEX_BITS+1:2];
    assign cpu_tag  = A[N_Bits-1:INDEX_BITS+2];
    assign req_idx  = req_addr[INDEX_BITS+1:2];
    assign req_tag  = req_addr[N_Bits-1:INDEX_BITS+2];
    assign cpu_hit  = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
    assign req_hit  = valid[req_idx] && (tag_arr[req_idx] == req_tag);

    // A simultaneous read+write is a store; reserved store size is a no-op
    assign is_store = MemWrite && (Storetype != 2'b11);
    assign is_load  = MemRead && !MemWrite;

    function automatic logic [N_Bits-1:0] merge_store(
        input logic [N_Bits-1:0] old_word,
        input logic [N_Bits-1:0] wd,
        input logic [1:0]        st,
        input logic [1:0]        lane
    );
        logic [N_Bits-1:0] m;
        m = old_word;
        case (st)
            2'b00:   m[{lane, 3'b000} +: 8]      = wd[7:0];
            2'b01:   m[{lane[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (is_store)                  state_next = WRITE_MEM;
                else if (is_load && !cpu_hit)  state_next = READ_MISS;
            end
            READ_MISS: if (mem_ready) state_next = IDLE;
            WRITE_MEM: if (mem_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        Stall = 1'b0;
        RD    = '0;
        case (state)
            IDLE: begin
                if (is_store) begin
                    Stall = 1'b1;
                end else if (is_load) begin
                    if (cpu_hit) RD = data_arr[cpu_idx];
                    else         Stall = 1'b1;
                end
            end
            READ_MISS: Stall = 1'b1;
            WRITE_MEM: Stall = ~mem_ready;
            default:   Stall = 1'b0;
        endcase
    end

    assign mem_req       = (state != IDLE);
    assign mem_we        = req_we;
    assign mem_A         = req_addr;
    assign mem_WD        = req_data;
    assign mem_storetype = req_type;

    // Request fields are captured only on leaving IDLE, so they hold steady for the whole transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr <= '0;
            req_data <= '0;
            req_type <= '0;
            req_we   <= 1'b0;
        end else if (state == IDLE) begin
            if (is_store) begin
                req_addr <= A;
                req_data <= WD;
                req_type <= Storetype;
                req_we   <= 1'b1;
            end else if (is_load && !cpu_hit) begin
                req_addr <= {A[N_Bits-1:2], 2'b00};
                req_type <= 2'b10;
                req_we   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == READ_MISS && mem_ready) begin
            data_arr[req_idx] <= mem_RD;
            tag_arr[req_idx]  <= req_tag;
        end else if (state == WRITE_MEM && mem_ready && req_hit) begin
            data_arr[req_idx] <= merge_store(data_arr[req_idx], req_data, req_type, req_addr[1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= (state == READ_MISS) && mem_ready;
            if (state == READ_MISS && mem_ready) valid[req_idx] <= 1'b1;
        end
    end

    // The held load's post-fill hit was already counted as a miss
    assign hit_inc  = (state == IDLE) && cpu_hit &&
                      (is_store || (is_load && !fill_done));
    assign miss_inc = (state == IDLE) && !cpu_hit && (is_store || is_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
            if (miss_inc && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 Parameter N_Bits, default 32, sets the data and address width.
REQ-002 Parameter LINES, default 16, sets the number of cache lines (power of two); INDEX_BITS = log2(LINES).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 MemRead  in  1  CPU load request, held by the CPU while Stall=1.
REQ-006 MemWrite  in  1  CPU store request, held by the CPU while Stall=1.
REQ-007 Storetype  in  2  store size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 A  in  N_Bits  CPU byte address.
REQ-009 WD  in  N_Bits  CPU store data.
REQ-010 RD  out  N_Bits  load data, the full aligned word.
REQ-011 Stall  out  1  freezes the CPU pipeline while high.
REQ-012 mem_req, mem_we  out  1 each  backing-memory request and write enable.
REQ-013 mem_storetype  out  2; mem_A  out  N_Bits; mem_WD  out  N_Bits  backing-memory request fields.
REQ-014 mem_RD  in  N_Bits; mem_ready  in  1  backing-memory read data and one-cycle completion strobe.
REQ-015 hit_count, miss_count  out  16 each  access statistics.

Function
REQ-016 Cache organisation: direct-mapped, one word per line; index = A[INDEX_BITS+1:2]; tag = A[N_Bits-1:INDEX_BITS+2]; one valid bit per line.
REQ-017 Write policy: write-through, no-write-allocate.
REQ-018 FSM states: IDLE, READ_MISS, WRITE_MEM.
REQ-019 IDLE, MemRead=1, MemWrite=0, hit: RD = cached word combinationally, Stall=0, no memory request.
REQ-020 IDLE, MemRead=1, miss: Stall=1 combinationally; register A word-aligned (A[1:0]=00); go to READ_MISS.
REQ-021 READ_MISS: mem_req=1, mem_we=0, mem_storetype=10; Stall=1.
REQ-022 READ_MISS on mem_ready: write mem_RD to the line, write tag, set valid, go to IDLE; the held load hits on the next cycle.
REQ-023 IDLE, MemWrite=1, Storetype!=11: Stall=1; register A, WD and Storetype; go to WRITE_MEM.
REQ-024 WRITE_MEM: mem_req=1, mem_we=1, registered fields on mem_A, mem_WD and mem_storetype; Stall = ~mem_ready.
REQ-025 WRITE_MEM on mem_ready: if the registered address hits, merge the store into the cached word; go to IDLE. The CPU retires the store on that edge.
REQ-026 Byte merge: lane A[1:0] (00 = bits 7:0 through 11 = bits 31:24) takes WD[7:0].
REQ-027 Half merge: A[1]=0 writes bits 15:0, A[1]=1 writes bits 31:16, from WD[15:0]; A[0] is ignored.
REQ-028 Store miss: the cache is not modified.
REQ-029 MemWrite=1 with Storetype=11: no-op; Stall=0, no request, cache unchanged, no counter change.
REQ-030 MemRead=1 and MemWrite=1 together: treated as a store; MemRead is ignored.
REQ-031 Outside READ_MISS and WRITE_MEM: mem_req=0; mem_A, mem_WD and mem_we hold their last values.
REQ-032 Once mem_req rises, it and all mem_* fields stay stable until the mem_ready cycle; mem_ready is ignored when mem_req=0.
REQ-033 hit_count increments once per load hit or store hit. A load that missed counts once as a miss, not again on its post-fill hit.
REQ-034 miss_count increments once per load miss or store miss, on entry to READ_MISS or WRITE_MEM.
REQ-035 Both counters saturate at 16'hFFFF.
REQ-036 RD is 0 when no load is active.

Reset
REQ-037 rst_n=0 immediately: state=IDLE, all valid bits cleared, counters=0, mem_req=0, mem_we=0, registered request fields=0, Stall=0.
REQ-038 Reset mid-transaction (READ_MISS or WRITE_MEM) drops mem_req at once. No line is filled or merged; a later mem_ready is ignored.
REQ-039 Tag and data arrays need not be reset; valid=0 masks them.

Verification
REQ-040 After reset, load A=0x40: Stall=1, mem_req with mem_A=0x40, mem_ready after 3 cycles with mem_RD=0xDEADBEEF -> next cycle RD=0xDEADBEEF, Stall=0, miss_count=1, hit_count=0.
REQ-041 Repeat load A=0x40 -> same-cycle hit, RD=0xDEADBEEF, no mem_req, hit_count=1.
REQ-042 Byte store A=0x42, WD=0x000000AA, mem_ready after 2 cycles -> mem_storetype=00, mem_A=0x42, Stall low in the mem_ready cycle; a later load of 0x40 returns 0xDEAABEEF.
REQ-043 Half store A=0x43, WD=0x1234 -> cached word 0x1234BEEF. Then a word store to miss address 0x80 -> memory write issued, no line for 0x80 becomes valid (a load of 0x80 misses).
REQ-044 Conflict: load 0x40, then load 0x80 (same index, different tag) -> second load misses and refills; a reload of 0x40 misses again.
REQ-045 rst_n pulsed low during READ_MISS -> mem_req=0 at once, valid bits cleared, mem_ready one cycle later ignored, next load of 0x40 misses. Storetype=11 store -> Stall=0, no mem_req.
